operand_fetch_stage: RTL and testbench

Decode-to-execute pipeline register for the RISC-V core, sitting directly downstream of `register_file`. It drives the register file read addresses and captures `read_data1`/`read_data2`. Captured operands are resolved against in-flight results: EX-stage forwarding and same-cycle writeback bypass. The block detects load-use hazards and presents a registered, valid/ready-handshaked operand bundle to the execute stage.

---
 rtl/operand_fetch_stage_if.sv | 38 +++
 rtl/operand_fetch_stage.sv | 134 +++++++++++++
 tb/tb_operand_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_stage_if.sv
// Decode/execute handshake bundle for operand_fetch_stage.
// master = the fetch stage itself, slave = the surrounding decode/execute logic.
interface operand_fetch_stage_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic              in_uses_rs1;
    logic              in_uses_rs2;
    logic [4:0]        in_rd;
    logic [CTRL_W-1:0] in_ctrl;

    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_rs1_val;
    logic [XLEN-1:0]   out_rs2_val;
    logic [4:0]        out_rd;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        input  in_valid, in_pc, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2, in_rd, in_ctrl,
        output in_ready,
        output out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd, out_ctrl,
        input  out_ready
    );

    modport slave (
        output in_valid, in_pc, in_rs1, in_rs2, in_uses_rs1, in_uses_rs2, in_rd, in_ctrl,
        input  in_ready,
        input  out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd, out_ctrl,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute register: operand read, EX/WB forwarding, load-use stall.
// Optional OPFETCH_STALL_CNT_EN adds a saturating count of stall cycles.
module operand_fetch_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_fetch_stage_if.master bus,
    output logic [4:0]           rf_rs1_addr,
    output logic [4:0]           rf_rs2_addr,
    input  logic [XLEN-1:0]      rf_rs1_data,
    input  logic [XLEN-1:0]      rf_rs2_data,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 ex_valid,
    input  logic [4:0]           ex_rd,
    input  logic [XLEN-1:0]      ex_data,
    input  logic                 ex_is_load,
    input  logic                 flush,
    output logic                 hazard_stall
`ifdef OPFETCH_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    logic              out_valid_r;
    logic [XLEN-1:0]   out_pc_r;
    logic [XLEN-1:0]   out_rs1_val_r;
    logic [XLEN-1:0]   out_rs2_val_r;
    logic [4:0]        out_rd_r;
    logic [CTRL_W-1:0] out_ctrl_r;

    logic [XLEN-1:0]   rs1_val_s;
    logic [XLEN-1:0]   rs2_val_s;
    logic              hazard_s;
    logic              ready_s;
    logic              capture_s;

    // EX beats WB because it is the younger producer; WB covers the RF write-through gap.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_data,
        input logic            f_ex_valid,
        input logic            f_ex_is_load,
        input logic [4:0]      f_ex_rd,
        input logic [XLEN-1:0] f_ex_data,
        input logic            f_wb_valid,
        input logic [4:0]      f_wb_rd,
        input logic [XLEN-1:0] f_wb_data
    );
        logic [XLEN-1:0] val;
        if (rs == 5'd0) begin
            val = {XLEN{1'b0}};
        end else if (f_ex_valid && !f_ex_is_load && (f_ex_rd == rs)) begin
            val = f_ex_data;
        end else if (f_wb_valid && (f_wb_rd == rs)) begin
            val = f_wb_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    assign rf_rs1_addr = bus.in_rs1;
    assign rf_rs2_addr = bus.in_rs2;

    // Operand resolution, hazard detection and handshake decisions.
    always_comb begin
        rs1_val_s = resolve(bus.in_rs1, rf_rs1_data, ex_valid, ex_is_load, ex_rd, ex_data,
                            wb_valid, wb_rd, wb_data);
        rs2_val_s = resolve(bus.in_rs2, rf_rs2_data, ex_valid, ex_is_load, ex_rd, ex_data,
                            wb_valid, wb_rd, wb_data);
        hazard_s  = bus.in_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((bus.in_uses_rs1 & (bus.in_rs1 == ex_rd)) |
                     (bus.in_uses_rs2 & (bus.in_rs2 == ex_rd)));
        ready_s   = !hazard_s & (!out_valid_r | bus.out_ready);
        capture_s = bus.in_valid & ready_s & !flush;
    end

    // Output bundle register: flush > capture > drain > hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_pc_r      <= {XLEN{1'b0}};
            out_rs1_val_r <= {XLEN{1'b0}};
            out_rs2_val_r <= {XLEN{1'b0}};
            out_rd_r      <= 5'd0;
            out_ctrl_r    <= {CTRL_W{1'b0}};
        end else if (flush) begin
            out_valid_r   <= 1'b0;
        end else if (capture_s) begin
            out_valid_r   <= 1'b1;
            out_pc_r      <= bus.in_pc;
            out_rs1_val_r <= rs1_val_s;
            out_rs2_val_r <= rs2_val_s;
            out_rd_r      <= bus.in_rd;
            out_ctrl_r    <= bus.in_ctrl;
        end else if (bus.out_ready) begin
            out_valid_r   <= 1'b0;
        end else begin
            out_valid_r   <= out_valid_r;
        end
    end

    assign bus.in_ready    = ready_s;
    assign hazard_stall    = hazard_s;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_pc      = out_pc_r;
    assign bus.out_rs1_val = out_rs1_val_r;
    assign bus.out_rs2_val = out_rs2_val_r;
    assign bus.out_rd      = out_rd_r;
    assign bus.out_ctrl    = out_ctrl_r;

`ifdef OPFETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating stall-cycle counter; only reset clears it, flush does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 16'd0;
        end else if (hazard_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: expected bundles queued at drive time,
// popped and compared whenever the stage hands a bundle to execute.
module tb_operand_fetch_stage;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   v1;
        logic [XLEN-1:0]   v2;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
    } bundle_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_fetch_stage_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();

    logic [4:0]      rf_rs1_addr, rf_rs2_addr;
    logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid, ex_is_load;
    logic [4:0]      ex_rd;
    logic [XLEN-1:0] ex_data;
    logic            flush;
    logic            hazard_stall;
`ifdef OPFETCH_STALL_CNT_EN
    logic [15:0]     stall_cnt;
`endif

    logic [XLEN-1:0] regs [32];
    assign rf_rs1_data = regs[rf_rs1_addr];
    assign rf_rs2_data = regs[rf_rs2_addr];

    operand_fetch_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.master),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_is_load(ex_is_load),
        .flush(flush), .hazard_stall(hazard_stall)
`ifdef OPFETCH_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int total = 0;
    int bad = 0;
    bundle_t exp_q[$];
    bundle_t mon_exp;
    bundle_t mon_got;

    // Scoreboard: a bundle leaves the stage on every negedge-sampled valid&ready.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            mon_got = {bus.out_pc, bus.out_rs1_val, bus.out_rs2_val, bus.out_rd, bus.out_ctrl};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_bundle got pc=%h rs1=%h rs2=%h", mon_got.pc, mon_got.v1, mon_got.v2);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL bundle got pc=%h rs1=%h rs2=%h rd=%0d ctrl=%h want pc=%h rs1=%h rs2=%h rd=%0d ctrl=%h",
                             mon_got.pc, mon_got.v1, mon_got.v2, mon_got.rd, mon_got.ctrl,
                             mon_exp.pc, mon_exp.v1, mon_exp.v2, mon_exp.rd, mon_exp.ctrl);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.in_valid = 1'b0; bus.in_uses_rs1 = 1'b0; bus.in_uses_rs2 = 1'b0;
        ex_valid = 1'b0; ex_is_load = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic offer(input logic [XLEN-1:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1, input logic u2,
                         input logic [CTRL_W-1:0] ctrl);
        bus.in_valid = 1'b1; bus.in_pc = pc; bus.in_rs1 = rs1; bus.in_rs2 = rs2;
        bus.in_rd = rd; bus.in_uses_rs1 = u1; bus.in_uses_rs2 = u2; bus.in_ctrl = ctrl;
    endtask

    task automatic push_exp(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] v1,
                            input logic [XLEN-1:0] v2, input logic [4:0] rd,
                            input logic [CTRL_W-1:0] ctrl);
        bundle_t b;
        b = {pc, v1, v2, rd, ctrl};
        exp_q.push_back(b);
    endtask

    task automatic test_reset;
        tick; tick;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1 || hazard_stall !== 1'b0) begin bad++; $display("FAIL reset_comb got rdy=%b hz=%b want 1/0", bus.in_ready, hazard_stall); end
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        offer(32'h0000_0040, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 16'h1111);
        tick;
        idle;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL first_accept got valid=%b want 1", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.out_valid, bus.out_pc, bus.out_rs1_val, bus.out_rs2_val, bus.out_rd, bus.out_ctrl} !== 118'd0) begin
            bad++; $display("FAIL async_reset got valid=%b pc=%h rs1=%h want all 0", bus.out_valid, bus.out_pc, bus.out_rs1_val);
        end
        tick;
        rst_n = 1'b1;
    endtask

    task automatic test_plain_read;
        bus.out_ready = 1'b1;
        offer(32'h0000_0100, 5'd5, 5'd6, 5'd10, 1'b1, 1'b1, 16'hA5A5);
        #1;
        total++; if (rf_rs1_addr !== 5'd5 || rf_rs2_addr !== 5'd6) begin bad++; $display("FAIL rf_addr got %0d/%0d want 5/6", rf_rs1_addr, rf_rs2_addr); end
        push_exp(32'h0000_0100, 32'h1234_5678, 32'h0000_00FF, 5'd10, 16'hA5A5);
        tick;
        idle;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL plain_valid got %b want 1", bus.out_valid); end
        tick;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL drain got valid=%b want 0", bus.out_valid); end
    endtask

    task automatic test_forward_priority;
        ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd = 5'd7; ex_data = 32'hAAAA_0001;
        wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'hBBBB_0002;
        offer(32'h0000_0104, 5'd7, 5'd8, 5'd11, 1'b1, 1'b1, 16'h0007);
        push_exp(32'h0000_0104, 32'hAAAA_0001, 32'h1000_0008, 5'd11, 16'h0007);
        tick;
        ex_rd = 5'd0; wb_rd = 5'd0;
        offer(32'h0000_0108, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 16'h0008);
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got %b want 1", bus.in_ready); end
        push_exp(32'h0000_0108, 32'h0000_0000, 32'h0000_0000, 5'd12, 16'h0008);
        tick;
        ex_rd = 5'd8; wb_rd = 5'd7;
        offer(32'h0000_010C, 5'd7, 5'd8, 5'd13, 1'b1, 1'b1, 16'h0009);
        push_exp(32'h0000_010C, 32'hBBBB_0002, 32'hAAAA_0001, 5'd13, 16'h0009);
        tick;
        idle;
        tick;
    endtask

    task automatic test_wb_bypass;
        bus.out_ready = 1'b1;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
        offer(32'h0000_0110, 5'd4, 5'd3, 5'd14, 1'b1, 1'b1, 16'h000A);
        push_exp(32'h0000_0110, 32'h1000_0004, 32'hDEAD_BEEF, 5'd14, 16'h000A);
        tick;
        idle;
        tick;
    endtask

    task automatic test_load_use;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9; ex_data = 32'hBAD0_BAD0;
        offer(32'h0000_0120, 5'd1, 5'd9, 5'd15, 1'b1, 1'b1, 16'h000B);
        #1;
        total++; if (hazard_stall !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL load_use got hz=%b rdy=%b want 1/0", hazard_stall, bus.in_ready); end
        tick;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bubble got valid=%b want 0", bus.out_valid); end
        ex_valid = 1'b0; ex_is_load = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h9999_0009;
        #1;
        total++; if (hazard_stall !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got hz=%b rdy=%b want 0/1", hazard_stall, bus.in_ready); end
        push_exp(32'h0000_0120, 32'h1000_0001, 32'h9999_0009, 5'd15, 16'h000B);
        tick;
        idle;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL after_stall got valid=%b want 1", bus.out_valid); end
        tick;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9;
        offer(32'h0000_0124, 5'd2, 5'd9, 5'd16, 1'b1, 1'b0, 16'h000C);
        #1;
        total++; if (hazard_stall !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL unused_src got hz=%b rdy=%b want 0/1", hazard_stall, bus.in_ready); end
        push_exp(32'h0000_0124, 32'h1000_0002, 32'h1000_0009, 5'd16, 16'h000C);
        tick;
        idle;
        tick;
    endtask

    task automatic test_backpressure;
        bus.out_ready = 1'b0;
        offer(32'h0000_0200, 5'd5, 5'd6, 5'd17, 1'b1, 1'b1, 16'h00A0);
        push_exp(32'h0000_0200, 32'h1234_5678, 32'h0000_00FF, 5'd17, 16'h00A0);
        tick;
        offer(32'h0000_0204, 5'd12, 5'd13, 5'd18, 1'b1, 1'b1, 16'h00A1);
        push_exp(32'h0000_0204, 32'h1000_000C, 32'h1000_000D, 5'd18, 16'h00A1);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h5A5A_5A5A;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0000_0200 ||
                bus.out_rs1_val !== 32'h1234_5678 || bus.out_ctrl !== 16'h00A0) begin
                bad++; $display("FAIL hold cyc=%0d got rdy=%b valid=%b pc=%h rs1=%h want 0/1/00000200/12345678", i, bus.in_ready, bus.out_valid, bus.out_pc, bus.out_rs1_val);
            end
            tick;
        end
        wb_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick;
        idle;
        tick;
        tick;
    endtask

    task automatic test_flush;
        bus.out_ready = 1'b1;
        offer(32'h0000_0300, 5'd1, 5'd2, 5'd19, 1'b1, 1'b1, 16'h00F0);
        flush = 1'b1;
        tick;
        idle;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_input got valid=%b want 0", bus.out_valid); end
        bus.out_ready = 1'b0;
        offer(32'h0000_0304, 5'd1, 5'd2, 5'd20, 1'b1, 1'b1, 16'h00F1);
        tick;
        idle;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_held got valid=%b want 0", bus.out_valid); end
        bus.out_ready = 1'b1;
        tick;
    endtask

    task automatic test_stall_count;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd9;
        offer(32'h0000_0400, 5'd9, 5'd1, 5'd21, 1'b1, 1'b1, 16'h0F00);
        tick;
        tick;
        total++; if (hazard_stall !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL held_hazard got hz=%b valid=%b want 1/0", hazard_stall, bus.out_valid); end
        idle;
`ifdef OPFETCH_STALL_CNT_EN
        #1;
        total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL stall_cnt got %0d want 2", stall_cnt); end
        flush = 1'b1;
        tick;
        flush = 1'b0;
        total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL stall_cnt_flush got %0d want 2", stall_cnt); end
`endif
        tick;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
        regs[0] = 32'h5555_5555;
        regs[3] = 32'h0000_0000;
        regs[5] = 32'h1234_5678;
        regs[6] = 32'h0000_00FF;
        regs[7] = 32'hCCCC_0007;
        bus.out_ready = 1'b0;
        bus.in_pc = 32'd0; bus.in_rs1 = 5'd0; bus.in_rs2 = 5'd0; bus.in_rd = 5'd0; bus.in_ctrl = 16'd0;
        ex_rd = 5'd0; ex_data = 32'd0; wb_rd = 5'd0; wb_data = 32'd0;
        idle;
        test_reset;
        test_plain_read;
        test_forward_priority;
        test_wb_bypass;
        test_load_use;
        test_backpressure;
        test_flush;
        test_stall_count;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expected got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
